round_multi: RTL and testbench
==============================

// Module: round_multi
// PURPOSE
//  Next-generation whack-a-mole round controller. Runs one round of MOLENUM moles with up to NSLOT moles
//  visible at once on NHOLE holes. Each mole has its own lifetime timer. Hits and misses are scored.
//  Sits between the game-level sequencer (config, round_start) and the hole display/keypad logic.
// PARAMETERS
//  NHOLE  16     number of holes; HW = $clog2(NHOLE) is the index width
//  NSLOT  2      max simultaneously visible moles (1..8)
//  CNT_W  27     width of the interval/duration timers
//  NUM_W  4      width of molenum and the score counters
//  SEED   16'hACE1  internal 16-bit LFSR seed (must be nonzero)
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      asynchronous active-low reset
//  round_start  in   1      start request; accepted only in IDLE
//  interval     in   CNT_W  cycles between spawn opportunities
//  duration     in   CNT_W  mole lifetime in cycles (0 treated as 1)
//  molenum      in   NUM_W  moles to spawn this round
//  hit          in   1      player strike (level; internally edge-detected)
//  hit_index    in   HW     hole struck
//  mole_mask    out  NHOLE  bit i = mole currently visible in hole i
//  round_over   out  1      1 while IDLE
//  round_done   out  1      1-cycle pulse on RUN->IDLE
//  hit_success  out  1      1-cycle pulse, registered: valid hit scored
//  hit_wrong    out  1      1-cycle pulse, registered: strike on empty hole
//  hit_count    out  NUM_W  hits this round, saturating
//  miss_count   out  NUM_W  expired moles this round, saturating
// BEHAVIOUR
//  Reset: state=IDLE; all slots inactive; mole_mask=0; round_over=1.
//   round_done, hit_success, hit_wrong, hit_count, miss_count = 0; LFSR=SEED; spawned=0.
//  FSM IDLE: on round_start, latch interval/duration/molenum.
//   Clear hit_count, miss_count, spawned, spawn timer. Go to RUN.
//  FSM RUN: when spawned==molenum and no slot active, go to IDLE next edge.
//   round_done pulses on that edge. round_start is ignored in RUN.
//  LFSR: 16-bit Galois, taps 16,14,13,11; advances every cycle in every state.
//   Candidate hole = lfsr[HW-1:0] mod NHOLE.
//  Spawn timer: 0 on RUN entry; increments each RUN cycle until == interval, then holds.
//   Spawn condition: timer==interval, spawned<molenum, a free slot exists, and the candidate
//   hole is not in pre-edge mole_mask. If all hold, load the lowest-numbered free slot with
//   index=candidate and life=max(duration,1). spawned++ and timer<=0.
//   Otherwise hold timer at interval; retry next cycle with the new LFSR value.
//   interval=0: spawn attempts every cycle.
//  Slot life: an active slot decrements life each cycle. On the edge where life==1 it
//   deactivates, so the mole is visible exactly max(duration,1) cycles. That expiry does
//   miss_count++ (saturating at 2^NUM_W-1).
//  Hit: strike = hit & ~hit_q, where hit_q is hit registered. A held hit counts once.
//   Strike matching an active slot's index (RUN only): that slot clears on the next edge,
//   hit_count++ (saturating), hit_success pulses the following cycle.
//   Strike on an empty hole, or while in IDLE: hit_wrong pulses; no score change.
//  Simultaneous events, same edge:
//   - hit and expiry on the same slot: hit wins (no miss).
//   - spawn uses pre-edge occupancy: a slot freed this edge is not reused until the next cycle.
//   - a hole being hit this edge blocks a spawn into it.
//   - last expiry plus spawned==molenum: RUN->IDLE happens one cycle later (the active check
//     is registered state).
//  molenum=0: RUN lasts one cycle, then IDLE with a round_done pulse.
//  Asynchronous reset mid-round returns everything to reset values immediately.
// TESTING
//  1. molenum=3, NSLOT=1, interval=2, duration=4, no hits -> 3 moles, each visible 4 cycles;
//     miss_count=3; round_done pulse.
//  2. Hit at the visible mole's index, 2 cycles after it appears -> mask bit clears next edge;
//     hit_success 1 cycle later; hit_count=1.
//  3. hit held high for 5 cycles over an active mole -> exactly one hit_success; hit_count=1.
//  4. NSLOT=2, interval=0, duration=10, molenum=4 -> never >2 bits set in mole_mask; never two
//     moles in the same hole; hit_count+miss_count=4 at round_done.
//  5. Hit on an empty hole, and hit during the expiry cycle of a mole -> hit_wrong only; then
//     hit_success with miss_count unchanged.
//  6. rst_n low mid-RUN, then round_start in IDLE with molenum=0 -> all outputs reset;
//     round_done 2 cycles after round_start.

Source files
------------

// File: rtl/round_multi.sv
// Whack-a-mole round controller: spawns up to NSLOT concurrent moles from an LFSR,
// times each mole's lifetime independently and scores hits, wrong strikes and misses.
module round_multi #(
  parameter int          NHOLE = 16,
  parameter int          NSLOT = 2,
  parameter int          CNT_W = 27,
  parameter int          NUM_W = 4,
  parameter logic [15:0] SEED  = 16'hACE1,
  localparam int         HW    = $clog2(NHOLE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             round_start,
  input  logic [CNT_W-1:0] interval,
  input  logic [CNT_W-1:0] duration,
  input  logic [NUM_W-1:0] molenum,
  input  logic             hit,
  input  logic [HW-1:0]    hit_index,
  output logic [NHOLE-1:0] mole_mask,
  output logic             round_over,
  output logic             round_done,
  output logic             hit_success,
  output logic             hit_wrong,
  output logic [NUM_W-1:0] hit_count,
  output logic [NUM_W-1:0] miss_count
);

  localparam int          SW   = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int unsigned MAXV = (32'd1 << NUM_W) - 32'd1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] int_r, dur_r, timer;
  logic [NUM_W-1:0] num_r, spawned;
  logic [15:0]      lfsr, lfsr_next;
  logic             hit_q, strike, valid_hit, have_free, do_spawn, all_done;
  logic [NSLOT-1:0] act, hit_slot, expire;
  logic [HW-1:0]    idx [NSLOT];
  logic [CNT_W-1:0] life [NSLOT];
  logic [CNT_W-1:0] life0;
  logic [SW-1:0]    free_slot;
  logic [HW-1:0]    cand;
  int unsigned      n_exp;
  logic [31:0]      miss_sum;
  logic [NUM_W-1:0] miss_next;

  assign strike     = hit & ~hit_q;
  assign cand       = HW'(32'(lfsr[HW-1:0]) % 32'(NHOLE));
  assign lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign life0      = (dur_r == '0) ? CNT_W'(1) : dur_r;
  assign round_over = (state == IDLE);

  // Occupancy, hit matching and free-slot search all use pre-edge slot state.
  always_comb begin
    mole_mask = '0;
    hit_slot  = '0;
    expire    = '0;
    have_free = 1'b0;
    free_slot = '0;
    n_exp     = 0;
    for (int unsigned s = 0; s < NSLOT; s++) begin
      if (act[s]) begin
        mole_mask[idx[s]] = 1'b1;
        if (strike && (state == RUN) && (idx[s] == hit_index))
          hit_slot[s] = 1'b1;
      end
    end
    for (int unsigned s = 0; s < NSLOT; s++) begin
      expire[s] = act[s] && (life[s] == CNT_W'(1)) && !hit_slot[s];
      if (expire[s]) n_exp = n_exp + 1;
    end
    for (int unsigned s = NSLOT; s > 0; s--) begin
      if (!act[s-1]) begin
        have_free = 1'b1;
        free_slot = SW'(s - 1);
      end
    end
  end

  assign valid_hit = |hit_slot;
  assign do_spawn  = (state == RUN) && (timer == int_r) && (spawned < num_r) && have_free &&
                     !mole_mask[cand] && !(strike && (hit_index == cand));
  assign all_done  = (state == RUN) && (spawned == num_r) && (act == '0);
  assign miss_sum  = 32'(miss_count) + n_exp;
  assign miss_next = (miss_sum > MAXV) ? NUM_W'(MAXV) : NUM_W'(miss_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      int_r       <= '0;
      dur_r       <= '0;
      num_r       <= '0;
      timer       <= '0;
      spawned     <= '0;
      lfsr        <= SEED;
      hit_q       <= 1'b0;
      act         <= '0;
      for (int unsigned s = 0; s < NSLOT; s++) begin
        idx[s]  <= '0;
        life[s] <= '0;
      end
      round_done  <= 1'b0;
      hit_success <= 1'b0;
      hit_wrong   <= 1'b0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      lfsr        <= lfsr_next;
      hit_q       <= hit;
      hit_success <= valid_hit;
      hit_wrong   <= strike && !valid_hit;
      round_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (round_start) begin
            int_r      <= interval;
            dur_r      <= duration;
            num_r      <= molenum;
            timer      <= '0;
            spawned    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          for (int unsigned s = 0; s < NSLOT; s++) begin
            if (act[s]) begin
              if (hit_slot[s] || (life[s] == CNT_W'(1))) act[s] <= 1'b0;
              else life[s] <= life[s] - 1'b1;
            end
          end
          if (do_spawn) begin
            act[free_slot]  <= 1'b1;
            idx[free_slot]  <= cand;
            life[free_slot] <= life0;
            spawned         <= spawned + 1'b1;
            timer           <= '0;
          end else if (timer != int_r) begin
            timer <= timer + 1'b1;
          end
          if (valid_hit && !(&hit_count)) hit_count <= hit_count + 1'b1;
          miss_count <= miss_next;
          if (all_done) begin
            state      <= IDLE;
            round_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_multi.sv
// Scoreboard bench for round_multi: directed rounds push expected pulse events,
// a negedge monitor pops and checks them along with spawn position and mole lifetimes.
module tb_round_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        round_start;
  logic [26:0] interval, duration;
  logic [3:0]  molenum;
  logic        hit;
  logic [3:0]  hit_index;
  logic [15:0] mole_mask;
  logic        round_over, round_done, hit_success, hit_wrong;
  logic [3:0]  hit_count, miss_count;

  round_multi #(.NHOLE(16), .NSLOT(2), .CNT_W(27), .NUM_W(4), .SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .round_start(round_start), .interval(interval),
    .duration(duration), .molenum(molenum), .hit(hit), .hit_index(hit_index),
    .mole_mask(mole_mask), .round_over(round_over), .round_done(round_done),
    .hit_success(hit_success), .hit_wrong(hit_wrong), .hit_count(hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event did not occur within bound at %0t", name, $time);
  endtask

  // Expected pulse events: kind 0=round_done 1=hit_success 2=hit_wrong
  typedef struct {
    int kind;
    int hc;
    int mc;
  } ev_t;
  ev_t q[$];

  task automatic push(input int k, input int h, input int m);
    ev_t e;
    e.kind = k;
    e.hc   = h;
    e.mc   = m;
    q.push_back(e);
  endtask

  task automatic pop_cmp(input int k);
    ev_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d required none at %0t", k, $time);
    end else begin
      e = q.pop_front();
      check("event_kind", k, e.kind);
      check("event_hit_count", 32'(hit_count), e.hc);
      check("event_miss_count", 32'(miss_count), e.mc);
    end
  endtask

  // Reference LFSR; lm_pre holds the value the DUT used before the latest edge.
  logic [15:0] lm, lm_pre;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lm     <= 16'hACE1;
      lm_pre <= 16'hACE1;
    end else begin
      lm     <= {1'b0, lm[15:1]} ^ (lm[0] ? 16'hB400 : 16'h0000);
      lm_pre <= lm;
    end
  end

  logic [15:0] prev_mask = '0;
  logic [15:0] newbits, onehot;
  int          run_len [16];
  logic        chk_life = 1'b0;
  int          exp_dur  = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (hit_success) pop_cmp(1);
      if (hit_wrong)   pop_cmp(2);
      if (round_done)  pop_cmp(0);
      newbits = mole_mask & ~prev_mask;
      if (newbits != '0) begin
        onehot = 16'd1 << lm_pre[3:0];
        check("spawn_hole", 32'(newbits), 32'(onehot));
      end
      check("max_slots", 32'($countones(mole_mask) <= 2), 32'd1);
      for (int b = 0; b < 16; b++) begin
        if (mole_mask[b]) run_len[b]++;
        else if (run_len[b] != 0) begin
          if (chk_life) check("mole_life", run_len[b], exp_dur);
          run_len[b] = 0;
        end
      end
      prev_mask = mole_mask;
    end else begin
      prev_mask = '0;
      for (int b = 0; b < 16; b++) run_len[b] = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_round(input int iv, input int dur, input int num);
    @(negedge clk);
    interval    = 27'(iv);
    duration    = 27'(dur);
    molenum     = 4'(num);
    round_start = 1'b1;
    @(negedge clk);
    round_start = 1'b0;
  endtask

  task automatic wait_mole(output logic [3:0] h);
    h = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mole_mask != '0) begin
        for (int b = 15; b >= 0; b--) if (mole_mask[b]) h = 4'(b);
        return;
      end
    end
    fail("mole_timeout");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (round_over) return;
    end
    fail("idle_timeout");
  endtask

  logic [3:0] h;

  initial begin
    rst_n = 1'b0; round_start = 1'b0; interval = '0; duration = '0;
    molenum = '0; hit = 1'b0; hit_index = '0;
    tick(3);
    check("rst_mask", 32'(mole_mask), 32'd0);
    check("rst_round_over", 32'(round_over), 32'd1);
    check("rst_round_done", 32'(round_done), 32'd0);
    check("rst_hit_success", 32'(hit_success), 32'd0);
    check("rst_hit_wrong", 32'(hit_wrong), 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_miss_count", 32'(miss_count), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Three unhit moles, each visible exactly 4 cycles
    chk_life = 1'b1; exp_dur = 4;
    push(0, 0, 3);
    start_round(2, 4, 3);
    wait_idle();
    chk_life = 1'b0;
    check("t1_miss_count", 32'(miss_count), 32'd3);
    tick(2);

    // Hit two cycles after the mole appears
    push(1, 1, 0);
    push(0, 1, 0);
    start_round(0, 8, 1);
    wait_mole(h);
    tick(2);
    hit_index = h; hit = 1'b1;
    tick(1);
    check("t2_hit_clear", 32'(mole_mask[h]), 32'd0);
    hit = 1'b0;
    wait_idle();
    check("t2_hit_count", 32'(hit_count), 32'd1);
    tick(2);

    // Held hit counts once
    push(1, 1, 0);
    push(0, 1, 0);
    start_round(0, 12, 1);
    wait_mole(h);
    hit_index = h; hit = 1'b1;
    tick(5);
    hit = 1'b0;
    wait_idle();
    check("t3_hit_count", 32'(hit_count), 32'd1);
    tick(2);

    // Two slots, back-to-back spawn attempts
    chk_life = 1'b1; exp_dur = 10;
    push(0, 0, 4);
    start_round(0, 10, 4);
    wait_idle();
    chk_life = 1'b0;
    check("t4_total", 32'(hit_count) + 32'(miss_count), 32'd4);
    tick(2);

    // Strike in IDLE, strike on empty hole, strike in a mole's expiry cycle
    push(2, 0, 4);
    hit_index = 4'd0; hit = 1'b1;
    tick(1);
    hit = 1'b0;
    tick(2);
    push(2, 0, 0);
    push(1, 1, 0);
    push(0, 1, 0);
    start_round(3, 6, 1);
    wait_mole(h);
    hit_index = h + 4'd1; hit = 1'b1;
    tick(1);
    hit = 1'b0;
    tick(4);
    hit_index = h; hit = 1'b1;
    tick(1);
    hit = 1'b0;
    check("t5_expiry_hit_clear", 32'(mole_mask[h]), 32'd0);
    check("t5_miss_unchanged", 32'(miss_count), 32'd0);
    wait_idle();
    tick(2);

    // Asynchronous reset mid-round, then an empty round
    push(1, 1, 0);
    start_round(0, 20, 3);
    wait_mole(h);
    hit_index = h; hit = 1'b1;
    tick(1);
    hit = 1'b0;
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_mask", 32'(mole_mask), 32'd0);
    check("t6_rst_round_over", 32'(round_over), 32'd1);
    check("t6_rst_hit_count", 32'(hit_count), 32'd0);
    check("t6_rst_miss_count", 32'(miss_count), 32'd0);
    check("t6_rst_pulses", 32'({round_done, hit_success, hit_wrong}), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    push(0, 0, 0);
    interval = 27'd0; duration = 27'd5; molenum = 4'd0; round_start = 1'b1;
    tick(1);
    round_start = 1'b0;
    check("t6_done_early", 32'(round_done), 32'd0);
    check("t6_running", 32'(round_over), 32'd0);
    tick(1);
    check("t6_done_pulse", 32'(round_done), 32'd1);
    check("t6_idle", 32'(round_over), 32'd1);
    tick(2);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
